// File: rtl/response_buffer_bridge.sv
`default_nettype none
// ============================================================================
// Module   : response_buffer_bridge
// Purpose  : Credit-gated response FIFO between a no-backpressure response
//            tree and a ready/valid master port.
// Revision : 1.0 - initial release
// ============================================================================
module response_buffer_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic                    req_gnt_i,
  output logic                    req_stall_o,
  input  logic                    data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   data_r_rdata_i,
  input  logic                    data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]    data_r_aux_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_opc_o,
  output logic [AUX_WIDTH-1:0]    resp_aux_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int c_ADDR_W  = $clog2(DEPTH);
  localparam int c_CNT_W   = c_ADDR_W + 1;
  localparam int c_ENTRY_W = DATA_WIDTH + 1 + AUX_WIDTH;

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_ADDR_W-1:0]  r_wptr;
  logic [c_ADDR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   r_credits;
  logic                 r_overflow;

  logic w_accept;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  assign req_stall_o = (r_credits == '0);
  assign w_accept    = req_valid_i & req_gnt_i & ~req_stall_o;
  assign resp_valid_o = (r_count != '0);
  assign w_pop       = resp_valid_o & resp_ready_i;
  assign w_full      = (r_count == c_CNT_W'(DEPTH));
  // A simultaneous pop frees the head slot, so a full FIFO can still take a push.
  assign w_push_ok   = data_r_valid_i & (~w_full | w_pop);
  assign w_drop      = data_r_valid_i & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= c_CNT_W'(DEPTH);
    end else if (w_accept && !w_pop) begin
      r_credits <= r_credits - c_CNT_W'(1);
    end else if (w_pop && !w_accept) begin
      r_credits <= r_credits + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ADDR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the head is only meaningful while resp_valid_o is high.
  always_ff @(posedge clk) begin
    if (w_push_ok && !rst) begin
      r_mem[r_wptr] <= {data_r_rdata_i, data_r_opc_i, data_r_aux_i};
    end
  end

  assign {resp_rdata_o, resp_opc_o, resp_aux_o} = r_mem[r_rptr];
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_response_buffer_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_buffer_bridge
// Purpose  : Directed + randomized scoreboard bench for response_buffer_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_buffer_bridge;

  localparam int DW    = 32;
  localparam int XW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [DW+XW:0] ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i, req_gnt_i, req_stall_o;
  logic          data_r_valid_i;
  logic [DW-1:0] data_r_rdata_i;
  logic          data_r_opc_i;
  logic [XW-1:0] data_r_aux_i;
  logic          resp_valid_o, resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_opc_o;
  logic [XW-1:0] resp_aux_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  response_buffer_bridge #(.DATA_WIDTH(DW), .AUX_WIDTH(XW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_gnt_i(req_gnt_i), .req_stall_o(req_stall_o),
    .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
    .data_r_opc_i(data_r_opc_i), .data_r_aux_i(data_r_aux_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_opc_o(resp_opc_o), .resp_aux_o(resp_aux_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  // Reference model: an ordered queue of expected responses plus a credit integer.
  ent_t exp_q[$];
  int   m_credits = DEPTH;
  bit   m_ovf     = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  bit   chk_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    int sz;
    bit pop, acc;
    sz = exp_q.size();
    if (chk_en) begin
      check("count", 64'(count_o), 64'(sz));
      check("resp_valid", 64'(resp_valid_o), 64'(sz != 0));
      check("stall", 64'(req_stall_o), 64'(m_credits == 0));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      if (resp_valid_o === 1'b1) begin
        if (sz == 0) begin
          check("head_unexpected", 64'(1), 64'(0));
        end else begin
          check("head", 64'({resp_rdata_o, resp_opc_o, resp_aux_o}), 64'(exp_q[0]));
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      m_credits = DEPTH;
      m_ovf     = 1'b0;
    end else begin
      pop = (sz != 0) && resp_ready_i;
      acc = req_valid_i && req_gnt_i && (m_credits != 0);
      if (pop) void'(exp_q.pop_front());
      if (data_r_valid_i) begin
        if (sz < DEPTH || pop) exp_q.push_back({data_r_rdata_i, data_r_opc_i, data_r_aux_i});
        else m_ovf = 1'b1;
      end
      m_credits = m_credits + int'(pop) - int'(acc);
    end
  end

  task automatic drive(input bit rv, input bit gnt, input bit dv, input logic [DW-1:0] d,
                       input bit opc, input logic [XW-1:0] aux, input bit rdy, input bit r = 1'b0);
    req_valid_i    = rv;
    req_gnt_i      = gnt;
    data_r_valid_i = dv;
    data_r_rdata_i = d;
    data_r_opc_i   = opc;
    data_r_aux_i   = aux;
    resp_ready_i   = rdy;
    rst            = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int outst;
    bit rv, gnt, dv, rdy, rr, acc;
    rst = 1'b1;
    req_valid_i = 0; req_gnt_i = 0; data_r_valid_i = 0;
    data_r_rdata_i = '0; data_r_opc_i = 0; data_r_aux_i = '0; resp_ready_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    drive(0, 0, 0, '0, 0, '0, 0, 1);

    // Fill credits, then a fifth grant that must be ignored
    repeat (4) drive(1, 1, 0, '0, 0, '0, 0);
    drive(1, 1, 0, '0, 0, '0, 0);
    check("stall_after_fill", 64'(req_stall_o), 64'(1));

    // Fill FIFO with head 0xDEADBEEF, then hold backpressure
    drive(0, 0, 1, 32'hDEADBEEF, 0, 8'h11, 0);
    drive(0, 0, 1, 32'h00002222, 1, 8'h22, 0);
    drive(0, 0, 1, 32'h00003333, 0, 8'h33, 0);
    drive(0, 0, 1, 32'h00004444, 1, 8'h44, 0);
    repeat (3) begin
      drive(0, 0, 0, '0, 0, '0, 0);
      check("bp_rdata", 64'(resp_rdata_o), 64'(32'hDEADBEEF));
    end

    // Push+pop at full, then a dropped push while full
    drive(0, 0, 1, 32'hCAFE0001, 1, 8'h55, 1);
    drive(0, 0, 1, 32'hBAD0BAD0, 0, 8'h66, 0);
    repeat (2) drive(0, 0, 0, '0, 0, '0, 0);
    drive(0, 0, 1, 32'h0BAD0BAD, 0, 8'h77, 0, 1);
    drive(0, 0, 0, '0, 0, '0, 0);
    check("rst_overflow", 64'(overflow_o), 64'(0));

    // Ordering with ready held high
    repeat (3) drive(1, 1, 0, '0, 0, '0, 1);
    drive(0, 0, 1, $urandom, 0, 8'h11, 1);
    drive(0, 0, 1, $urandom, 1, 8'h22, 1);
    check("order_first", 64'(resp_aux_o), 64'(8'h22));
    drive(0, 0, 1, $urandom, 0, 8'h33, 1);
    repeat (2) drive(0, 0, 0, '0, 0, '0, 1);

    // Wrap: ten request/response pairs streamed through
    drive(1, 1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(i < 9, 1, 1, $urandom, 1'($urandom), 8'(i), 1);
      check("wrap_count_le1", 64'(count_o <= 1), 64'(1));
    end
    repeat (3) drive(0, 0, 0, '0, 0, '0, 1);
    repeat (4) drive(1, 1, 0, '0, 0, '0, 0);
    outst = 4;

    // Randomized traffic with occasional mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 149) == 0);
      rv  = 1'($urandom);
      gnt = 1'($urandom);
      acc = rv && gnt && !req_stall_o && !rr;
      dv  = rr ? 1'($urandom) : ((outst > 0) && ($urandom_range(0, 2) != 0));
      rdy = ($urandom_range(0, 3) != 0);
      drive(rv, gnt, dv, $urandom, 1'($urandom), 8'($urandom), rdy, rr);
      if (rr) outst = 0;
      else outst = outst + int'(acc) - int'(dv);
    end
    repeat (8) drive(0, 0, 0, '0, 0, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/response_buffer_bridge.md
RESPONSE_BUFFER_BRIDGE -- requirements
Module: response_buffer_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, response data width.
REQ-002 The block SHALL have parameter AUX_WIDTH, default 8, response auxiliary (ID) width.
REQ-003 The block SHALL have parameter DEPTH, default 4, FIFO entries; legal values are powers of 2 and at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_valid_i  input  1  master request is present toward the request tree.
REQ-007 req_gnt_i  input  1  grant for that request from the request tree.
REQ-008 req_stall_o  output  1  high means no response credit is left; the master request SHALL be masked.
REQ-009 data_r_valid_i  input  1  response valid from the response fan-in tree.
REQ-010 data_r_rdata_i  input  DATA_WIDTH  response data from the tree.
REQ-011 data_r_opc_i  input  1  response opcode/error bit from the tree.
REQ-012 data_r_aux_i  input  AUX_WIDTH  response aux/ID from the tree.
REQ-013 resp_valid_o  output  1  head FIFO entry is valid toward the master.
REQ-014 resp_ready_i  input  1  master accepts the head entry.
REQ-015 resp_rdata_o, resp_opc_o, resp_aux_o  output  DATA_WIDTH/1/AUX_WIDTH  head entry fields.
REQ-016 count_o  output  clog2(DEPTH)+1  number of stored entries.
REQ-017 overflow_o  output  1  sticky flag: a response was dropped.

Function
REQ-018 The tree has no backpressure, so each accepted response SHALL always be stored; the credit mechanism guarantees space.
REQ-019 The credit counter SHALL be clog2(DEPTH)+1 bits wide and reset to DEPTH.
REQ-020 Request accept = req_valid_i & req_gnt_i & !req_stall_o; each accept SHALL decrement credits by 1.
REQ-021 Pop = resp_valid_o & resp_ready_i; each pop SHALL increment credits by 1.
REQ-022 Accept and pop in the same cycle SHALL leave credits unchanged.
REQ-023 req_stall_o SHALL be combinational (credits == 0).
REQ-024 A grant while req_stall_o is high SHALL be ignored; credits SHALL NOT underflow.
REQ-025 Push = data_r_valid_i; a push SHALL write {rdata, opc, aux} at the write pointer and advance it modulo DEPTH.
REQ-026 Pop SHALL advance the read pointer modulo DEPTH.
REQ-027 Pointers SHALL wrap naturally, with no bubble at the wrap point.
REQ-028 Latency: a push into an empty FIFO at edge N SHALL make resp_valid_o high after edge N; there is no combinational bypass.
REQ-029 resp_valid_o SHALL equal (count_o != 0).
REQ-030 resp_* data SHALL be driven from the head entry and SHALL stay stable while resp_valid_o & !resp_ready_i.
REQ-031 A push while full (count_o == DEPTH) with a simultaneous pop SHALL be accepted, and count_o SHALL be unchanged.
REQ-032 A push while full without a pop SHALL be dropped, FIFO contents and pointers unchanged, and overflow_o SHALL be set.
REQ-033 overflow_o SHALL clear only on reset.
REQ-034 A pop while empty is impossible by REQ-029 and SHALL NOT change any state.
REQ-035 Push and pop together on a non-empty, non-full FIFO SHALL leave count_o unchanged and preserve order.

Reset
REQ-036 On rst high at a rising edge: pointers 0, count_o 0, credits DEPTH, overflow_o 0, resp_valid_o 0, req_stall_o 0.
REQ-037 Reset mid-operation SHALL discard all stored and in-flight responses.
REQ-038 Responses arriving in the cycle of reset SHALL be discarded.
REQ-039 FIFO storage SHALL need no reset; resp_rdata_o is don't-care while resp_valid_o is low.

Verification
REQ-040 Fill: DEPTH=4, 4 accepted requests, no pops -> req_stall_o high after the 4th edge; a 5th grant is ignored and credits stay 0.
REQ-041 Ordering: push aux 0x11, 0x22, 0x33 with resp_ready_i=1 -> the same order appears on resp_aux_o, one per cycle, first one cycle after its push.
REQ-042 Backpressure: resp_ready_i=0 for 3 cycles with the head at 0xDEADBEEF -> resp_rdata_o stable, resp_valid_o held high.
REQ-043 Full boundary: full FIFO, push + pop in the same cycle -> count_o stays 4, overflow_o stays 0; the new entry emerges after 3 more pops.
REQ-044 Overflow: full FIFO, push with resp_ready_i=0 -> overflow_o=1 and remains 1; contents intact; rst -> overflow_o=0, count_o=0, req_stall_o=0.
REQ-045 Wrap: 10 push/pop pairs with DEPTH=4 -> no data loss, count_o never exceeds 1, credits return to 4.
